// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: command encodings,
// default geometry and the controller state enum.
package regfile_sequencer_pkg;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned SEL_W_DEF    = 5;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned MODE_W       = 2;

    localparam logic [MODE_W-1:0] MODE_DUMP  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 2'b10;
    localparam logic [MODE_W-1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DUMP  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Bus-side initiator for the register file. Walks every register index in
// order, either dumping contents onto an outbound valid/ready stream or
// loading an inbound stream into r1..r(NUM_REGS-1); can also issue a
// one-cycle bank clear. Owns the register-file pins while busy.
//
// Ports:
//   clock, rst                 - clock, asynchronous active-high reset
//   start, mode                - command strobe and command (sampled in IDLE)
//   busy, done, err            - status; done/err are one-cycle pulses
//   out_valid/out_ready/out_data - dump stream (out_data combinational)
//   in_valid/in_ready/in_data  - load stream
//   rf_readSel, rf_readOut     - register file read port 1
//   rf_writeSel, rf_data, rf_we - register file write port (registered)
//   rf_rst                     - register file synchronous clear request
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SEL_W-1:0]  rf_readSel,
    input  logic [DATA_W-1:0] rf_readOut,
    output logic [SEL_W-1:0]  rf_writeSel,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_we,
    output logic              rf_rst
);

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W-1:0] FIRST_LD  = SEL_W'(1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    wsel_q, wsel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // State, index and write-port registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wsel_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and write-port capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        we_d    = 1'b0;
        wsel_d  = wsel_q;
        wdata_d = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (mode)
                        MODE_DUMP: begin
                            state_d = ST_DUMP;
                            idx_d   = '0;
                        end
                        MODE_LOAD: begin
                            state_d = ST_LOAD;
                            idx_d   = FIRST_LD;
                        end
                        MODE_CLEAR: state_d = ST_CLEAR;
                        default:    err_d   = 1'b1;
                    endcase
                end
            end
            ST_DUMP: begin
                // out_valid is always high here, so out_ready alone completes the handshake
                if (out_ready) begin
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                    else                   idx_d   = idx_q + SEL_W'(1);
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    we_d    = 1'b1;
                    wsel_d  = idx_q;
                    wdata_d = in_data;
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                    else                   idx_d   = idx_q + SEL_W'(1);
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status and stream strobes are direct decodes of the state register
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign out_valid   = (state_q == ST_DUMP);
    assign in_ready    = (state_q == ST_LOAD);
    assign rf_rst      = (state_q == ST_CLEAR);
    assign rf_readSel  = idx_q;
    assign out_data    = rf_readOut;
    assign rf_we       = we_q;
    assign rf_writeSel = wsel_q;
    assign rf_data     = wdata_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural register file.
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        busy, done, err;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic [4:0]  rf_readSel, rf_writeSel;
    logic [31:0] rf_readOut, rf_data;
    logic        rf_we, rf_rst;

    regfile_sequencer dut (
        .clock(clock), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rf_readSel(rf_readSel), .rf_readOut(rf_readOut),
        .rf_writeSel(rf_writeSel), .rf_data(rf_data),
        .rf_we(rf_we), .rf_rst(rf_rst)
    );

    always #5 clock = ~clock;

    // Behavioural 32x32 register file, r0 hardwired to zero
    logic [31:0] mem [32];
    always @(posedge clock) begin
        if (rf_rst) begin
            for (int j = 0; j < 32; j++) mem[j] <= 32'h0;
        end else if (rf_we && rf_writeSel != 5'd0) begin
            mem[rf_writeSel] <= rf_data;
        end
    end
    assign rf_readOut = (rf_readSel == 5'd0) ? 32'h0 : mem[rf_readSel];

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic [31:0] oq [$];
    wr_t         wq [$];
    logic [31:0] exp_rf [32];
    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int rst_cnt     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // Monitor: pops expected stream words and register writes as the DUT presents them
    always @(negedge clock) begin
        if (!rst) begin
            check("excl_we_rst", 32'(rf_we & rf_rst), 32'h0);
            check("excl_valid_ready", 32'(out_valid & in_ready), 32'h0);
            if (out_valid) begin
                if (oq.size() == 0) fail("dump_unexpected", "out_valid with empty queue");
                else begin
                    check("dump_word", out_data, oq[0]);
                    if (out_ready) void'(oq.pop_front());
                end
            end
            if (rf_we) begin
                wr_t w;
                we_cnt++;
                if (wq.size() == 0) fail("wr_unexpected", "rf_we with empty queue");
                else begin
                    w = wq.pop_front();
                    check("wr_sel", 32'(rf_writeSel), 32'(w.sel));
                    check("wr_data", rf_data, w.data);
                end
            end
            if (rf_rst) rst_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(busy),        32'h0);
        check({tag, "_done"},     32'(done),        32'h0);
        check({tag, "_err"},      32'(err),         32'h0);
        check({tag, "_ovalid"},   32'(out_valid),   32'h0);
        check({tag, "_iready"},   32'(in_ready),    32'h0);
        check({tag, "_we"},       32'(rf_we),       32'h0);
        check({tag, "_rfrst"},    32'(rf_rst),      32'h0);
        check({tag, "_rsel"},     32'(rf_readSel),  32'h0);
        check({tag, "_wsel"},     32'(rf_writeSel), 32'h0);
        check({tag, "_wdata"},    rf_data,          32'h0);
        check({tag, "_odata"},    out_data,         32'h0);
    endtask

    task automatic start_cmd(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        mode  = MODE_RSVD;
    endtask

    task automatic do_load(input logic [31:0] base, input bit gapped, input int abort_at);
        int we0 = we_cnt;
        start_cmd(MODE_LOAD);
        check("load_busy", 32'(busy), 32'h1);
        for (int i = 1; i < 32; i++) begin
            if (gapped && (i % 3 == 0)) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                @(posedge clock); #1;
            end
            check("load_in_ready", 32'(in_ready), 32'h1);
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            wq.push_back('{sel: 5'(i), data: base + 32'(i)});
            @(posedge clock); #1;
            in_valid = 1'b0;
            in_data  = 32'h0;
            if (abort_at == i) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                check("abort_pending_wr", 32'(wq.size()), 32'h1);
                wq.delete();
                @(posedge clock); #1;
                rst = 1'b0;
                check("abort_we_count", 32'(we_cnt - we0), 32'd9);
                return;
            end
            if (i == 31) begin
                check("load_done_last", 32'(done), 32'h1);
                check("load_we_last", 32'(rf_we), 32'h1);
            end else begin
                check("load_done_early", 32'(done), 32'h0);
            end
        end
        @(posedge clock); #1;
        check("load_busy_end", 32'(busy), 32'h0);
        check("load_we_count", 32'(we_cnt - we0), 32'd31);
        for (int i = 1; i < 32; i++) exp_rf[i] = base + 32'(i);
    endtask

    task automatic do_dump(input bit toggle);
        int n;
        for (int i = 0; i < 32; i++) oq.push_back(exp_rf[i]);
        out_ready = 1'b1;
        start_cmd(MODE_DUMP);
        n = 1;
        check("dump_first_valid", 32'(out_valid), 32'h1);
        check("dump_busy", 32'(busy), 32'h1);
        while (!done && n < 200) begin
            if (!toggle && n == 10) begin
                start = 1'b1;
                mode  = MODE_LOAD;
            end else begin
                start = 1'b0;
            end
            out_ready = toggle ? (n % 2 == 1) : 1'b1;
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
        if (!done) fail("dump_timeout", "no done within 200 cycles");
        if (!toggle) check("dump_latency", 32'(n), 32'd33);
        check("dump_drained", 32'(oq.size()), 32'h0);
        out_ready = 1'b0;
        @(posedge clock); #1;
        check("dump_busy_end", 32'(busy), 32'h0);
        oq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst = 1'b1; start = 1'b0; mode = MODE_DUMP;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clock); #1;

        do_load(32'hA000_0000, 1'b0, 0);
        do_dump(1'b0);

        // Reserved mode: err pulse, no busy
        start_cmd(MODE_RSVD);
        check("err_pulse", 32'(err), 32'h1);
        check("err_busy", 32'(busy), 32'h0);
        @(posedge clock); #1;
        check("err_clear", 32'(err), 32'h0);
        check("err_busy2", 32'(busy), 32'h0);

        do_load(32'h5A5A_0000, 1'b1, 0);
        do_dump(1'b1);

        do_load(32'h1234_0000, 1'b0, 10);
        do_load(32'hC0DE_0000, 1'b0, 0);
        do_dump(1'b0);

        // Bank clear
        r0 = rst_cnt;
        start_cmd(MODE_CLEAR);
        check("clr_rfrst", 32'(rf_rst), 32'h1);
        check("clr_busy", 32'(busy), 32'h1);
        check("clr_done_early", 32'(done), 32'h0);
        @(posedge clock); #1;
        check("clr_done", 32'(done), 32'h1);
        check("clr_rfrst_off", 32'(rf_rst), 32'h0);
        @(posedge clock); #1;
        check("clr_busy_end", 32'(busy), 32'h0);
        check("clr_pulse_count", 32'(rst_cnt - r0), 32'h1);
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
        do_dump(1'b0);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
